// File: rtl/nv_nvdla_pdp_info_fifo_flopram.sv
// nv_nvdla_pdp_info_fifo_flopram
// Flop-array FIFO carrying PDP per-cube info words (cal1d kernel/line tags)
// from the cal1d front-end to the cal1d datapath. Storage is plain flops;
// pwrbus_ram_pd exists only for interface compatibility.
// Optional feature: define NV_NVDLA_PDP_INFO_FIFO_BYPASS_EN to let a word
// flow straight from wr_pd to rd_pd while the FIFO is empty.
module nv_nvdla_pdp_info_fifo_flopram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CNT_W-1:0] wr_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             bypass_take;
  logic             unused_pwrbus;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // The power bus has no functional effect on a flop-based array
  assign unused_pwrbus = ^pwrbus_ram_pd;

  // Flags come only from the registered count, so rd_prdy never reaches wr_prdy
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign wr_prdy    = ~fifo_full;
  assign wr_count   = count;

  // A stored word is popped only when one is actually held; rd_prdy is
  // ignored while empty
  assign pop = ~fifo_empty & rd_prdy;

`ifdef NV_NVDLA_PDP_INFO_FIFO_BYPASS_EN
  // Empty FIFO presents the incoming word directly; if it is taken in the
  // same cycle it never touches storage
  assign bypass_take = fifo_empty & wr_pvld & rd_prdy;
  assign rd_pvld     = ~fifo_empty | wr_pvld;
  assign rd_pd       = fifo_empty ? wr_pd : ram[rd_ptr];
`else
  assign bypass_take = 1'b0;
  assign rd_pvld     = ~fifo_empty;
  assign rd_pd       = ram[rd_ptr];
`endif

  // Full blocks writes even when a pop happens in the same cycle
  assign push = wr_pvld & ~fifo_full & ~bypass_take;

  // Storage write; the array is intentionally not reset
  always_ff @(posedge nvdla_core_clk) begin
    if (push) begin
      ram[wr_ptr] <= wr_pd;
    end
  end

  // Pointer and occupancy update; reset discards all contents at once
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
